// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for a small RV32 core: word RAM plus an MMIO window with
// GPIO, a console byte FIFO, a 64-bit cycle counter and a sticky status register.
module rv32_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int unsigned TX_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  output logic [31:0] mem_read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [31:0] gpio_out,
  output logic        bus_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [63:0]   cycle;
  logic [31:0]   shadow_hi;
  logic [31:0]   gpio_reg;
  logic          err_reg;

  logic [31:0]   off;
  logic [AW-1:0] ram_idx;
  logic          aligned, ram_hit, mmio_hit, mapped;
  logic          wr_ok, rd_ok, acc_err;
  logic          st_wr, push, pop, full, push_acc;

  // TX register layout: count at the LSBs, then full, then overflow.
  function automatic logic [31:0] tx_status(input logic ovf, input logic full_f,
                                            input logic [PW-1:0] cnt);
    tx_status = '0;
    tx_status[PW-1:0] = cnt;
    tx_status[PW]     = full_f;
    tx_status[PW+1]   = ovf;
  endfunction

  assign off      = mem_address - MMIO_BASE;
  assign ram_idx  = mem_address[AW+1:2];
  assign aligned  = (mem_address[1:0] == 2'b00);
  assign ram_hit  = (mem_address < RAM_BYTES);
  assign mmio_hit = (mem_address >= MMIO_BASE) && (off < 32'h14);
  assign mapped   = ram_hit || mmio_hit;

  assign wr_ok   = mem_write_en && aligned && mapped;
  assign rd_ok   = mem_read_en && aligned && mapped;
  assign acc_err = ((mem_write_en || mem_read_en) && (!aligned || !mapped)) ||
                   (mem_write_en && mem_read_en);

  assign st_wr    = wr_ok && mmio_hit && (off == 32'h10);
  assign push     = wr_ok && mmio_hit && (off == 32'h04);
  assign full     = (count == FULL_CNT);
  assign pop      = console_valid && console_ready;
  assign push_acc = push && (!full || pop);

  assign console_valid = (count != '0);
  assign console_data  = console_valid ? fifo[rd_ptr] : 8'h00;
  assign gpio_out      = gpio_reg;
  assign bus_error     = err_reg;

  always_comb begin
    mem_read_data = 32'h0;
    if (rd_ok) begin
      if (ram_hit) begin
        mem_read_data = ram[ram_idx];
      end else begin
        case (off)
          32'h00:  mem_read_data = gpio_reg;
          32'h04:  mem_read_data = tx_status(overflow, full, count[PW-1:0]);
          32'h08:  mem_read_data = cycle[31:0];
          32'h0C:  mem_read_data = shadow_hi;
          32'h10:  mem_read_data = {30'b0, overflow, err_reg};
          default: mem_read_data = 32'h0;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; only the pointers/count decide what is live.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok && ram_hit) ram[ram_idx] <= mem_write_data;
    if (push_acc) fifo[wr_ptr] <= mem_write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_reg  <= '0;
      err_reg   <= 1'b0;
      overflow  <= 1'b0;
      cycle     <= '0;
      shadow_hi <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (wr_ok && mmio_hit && (off == 32'h00)) gpio_reg <= mem_write_data;
      if (rd_ok && mmio_hit && (off == 32'h08)) shadow_hi <= cycle[63:32];

      // A new error outranks a software clear in the same cycle.
      if (acc_err) err_reg <= 1'b1;
      else if (st_wr && mem_write_data[0]) err_reg <= 1'b0;

      if (push && full && !pop) overflow <= 1'b1;
      else if (st_wr && mem_write_data[1]) overflow <= 1'b0;

      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
